// File: rtl/raycast_slave_mc_if.sv
// Wishbone classic-cycle bundle between the CPU bus and the ray-caster control slave.
interface raycast_slave_mc_if;
  logic [7:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic       wb_we_i;
  logic       wb_cyc_i;
  logic       wb_stb_i;
  logic [2:0] wb_cti_i;
  logic [1:0] wb_bte_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;
  logic       wb_err_o;
  logic       wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/raycast_slave_mc.sv
// Multi-core ray-caster control slave: 8-bit Wishbone register file holding the
// shared frame configuration, a start/abort sequencer over N_CORES cores with
// per-core completion tracking, sticky DONE/ERR status and a maskable interrupt.
// Optional macro RAYC_PERF_CNT_EN adds a frame cycle counter and coherent
// 32-bit snapshot reads of the hit/miss/cycle performance registers.
module raycast_slave_mc #(
  parameter int          N_CORES         = 4,
  parameter logic [31:0] RAY_BUF_ADR_RST = 32'd83886084,
  parameter logic [31:0] RAY_COUNT_RST   = 32'd307200,
  parameter logic [31:0] OCTREE_ADR_RST  = 32'd100857520,
  parameter logic [31:0] FB_ADR_RST      = 32'd0
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  raycast_slave_mc_if.slave    wb,
  output logic [N_CORES-1:0]   rayc_start_o,
  output logic                 rayc_abort_o,
  output logic [31:0]          ray_buf_adr_o,
  output logic [31:0]          ray_buf_count_o,
  output logic [31:0]          octree_adr_o,
  output logic [31:0]          fb_adr_o,
  input  logic [N_CORES-1:0]   rayc_finished_i,
  input  logic [31:0]          cache_hits_i,
  input  logic [31:0]          cache_miss_i,
  output logic                 irq_o
);

  localparam logic [0:0]         ST_IDLE    = 1'b0;
  localparam logic [0:0]         ST_RUN     = 1'b1;
  localparam logic [N_CORES-1:0] CORES_NONE = {N_CORES{1'b0}};
  localparam logic [N_CORES-1:0] CORES_ALL  = {N_CORES{1'b1}};

  // Big-endian byte lane select: offset 0 is bits [31:24].
  function automatic logic [7:0] get_byte(input logic [31:0] v, input logic [1:0] off);
    case (off)
      2'd0:    get_byte = v[31:24];
      2'd1:    get_byte = v[23:16];
      2'd2:    get_byte = v[15:8];
      default: get_byte = v[7:0];
    endcase
  endfunction

  // Big-endian byte lane replace.
  function automatic logic [31:0] put_byte(input logic [31:0] v, input logic [1:0] off,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = v;
    case (off)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    put_byte = r;
  endfunction

  logic               ack_r, irq_r, done_r, err_r, abort_r;
  logic [7:0]         dat_r;
  logic [N_CORES-1:0] start_r, mask_r, pending_r;
  logic [31:0]        ray_buf_r, ray_cnt_r, octree_r, fb_r;
  logic [2:0]         irq_en_r;
  logic [0:0]         state_r;

  logic               accept_s, wr_s, rd_s, busy_s, ctrl_wr_s, start_req_s, abort_req_s;
  logic               cfg_wr_s, cfg_ok_s, launch_s, finish_s, err_set_s;
  logic [7:0]         w1c_s, mask_byte_s, perf_byte_s, rd_byte_s;
  logic [N_CORES-1:0] pending_next_s;
  logic               unused_s;

  assign accept_s       = wb.wb_cyc_i & wb.wb_stb_i & ~ack_r;
  assign wr_s           = accept_s & wb.wb_we_i;
  assign rd_s           = accept_s & ~wb.wb_we_i;
  assign busy_s         = (state_r == ST_RUN);
  assign ctrl_wr_s      = wr_s & (wb.wb_adr_i == 8'h00);
  // Abort dominates: a simultaneous start request is dropped without error.
  assign abort_req_s    = ctrl_wr_s & wb.wb_dat_i[1];
  assign start_req_s    = ctrl_wr_s & wb.wb_dat_i[0] & ~wb.wb_dat_i[1];
  assign cfg_wr_s       = wr_s & (wb.wb_adr_i >= 8'h03) & (wb.wb_adr_i <= 8'h13);
  assign cfg_ok_s       = cfg_wr_s & ~busy_s;
  assign launch_s       = start_req_s & ~busy_s & (mask_r != CORES_NONE);
  assign pending_next_s = pending_r & ~rayc_finished_i;
  assign finish_s       = busy_s & ~abort_req_s & (pending_next_s == CORES_NONE);
  // Errors: config write while running, start while running, start with no cores.
  assign err_set_s      = (cfg_wr_s & busy_s) | (start_req_s & (busy_s | (mask_r == CORES_NONE)));
  assign w1c_s          = (wr_s && (wb.wb_adr_i == 8'h01)) ? wb.wb_dat_i : 8'h00;

  // Widen the core mask to a byte; unused upper bits read as zero.
  always_comb begin
    mask_byte_s = 8'h00;
    mask_byte_s[N_CORES-1:0] = mask_r;
  end

`ifdef RAYC_PERF_CNT_EN
  logic [31:0] cyc_cnt_r, shadow_r;

  // Frame cycle counter: cleared at launch, counts RUN cycles, saturates, holds when idle.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      cyc_cnt_r <= 32'h0000_0000;
    end else if (launch_s) begin
      cyc_cnt_r <= 32'h0000_0000;
    end else if (busy_s && (cyc_cnt_r != 32'hFFFF_FFFF)) begin
      cyc_cnt_r <= cyc_cnt_r + 32'd1;
    end
  end

  // Snapshot the whole source word when its most-significant byte is read.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      shadow_r <= 32'h0000_0000;
    end else if (rd_s) begin
      case (wb.wb_adr_i)
        8'h14:   shadow_r <= cache_hits_i;
        8'h18:   shadow_r <= cache_miss_i;
        8'h1C:   shadow_r <= cyc_cnt_r;
        default: shadow_r <= shadow_r;
      endcase
    end
  end

  // Perf read lanes: live MSB on the first byte, shadow for the remaining three.
  always_comb begin
    perf_byte_s = 8'h00;
    case (wb.wb_adr_i)
      8'h14:   perf_byte_s = cache_hits_i[31:24];
      8'h18:   perf_byte_s = cache_miss_i[31:24];
      8'h1C:   perf_byte_s = cyc_cnt_r[31:24];
      8'h15, 8'h16, 8'h17, 8'h19, 8'h1A, 8'h1B, 8'h1D, 8'h1E, 8'h1F:
               perf_byte_s = get_byte(shadow_r, wb.wb_adr_i[1:0]);
      default: perf_byte_s = 8'h00;
    endcase
  end

  assign unused_s = ^{wb.wb_cti_i, wb.wb_bte_i};
`else
  // Perf registers absent: the whole window reads zero.
  always_comb begin
    perf_byte_s = 8'h00;
  end

  assign unused_s = ^{wb.wb_cti_i, wb.wb_bte_i, cache_hits_i, cache_miss_i};
`endif

  // Register read multiplexer, indexed by byte address.
  always_comb begin
    rd_byte_s = 8'h00;
    case (wb.wb_adr_i[7:2])
      6'h00: begin
        case (wb.wb_adr_i[1:0])
          2'd1:    rd_byte_s = {5'b00000, err_r, busy_s, done_r};
          2'd2:    rd_byte_s = {5'b00000, irq_en_r};
          2'd3:    rd_byte_s = mask_byte_s;
          default: rd_byte_s = 8'h00;
        endcase
      end
      6'h01:               rd_byte_s = get_byte(ray_buf_r, wb.wb_adr_i[1:0]);
      6'h02:               rd_byte_s = get_byte(ray_cnt_r, wb.wb_adr_i[1:0]);
      6'h03:               rd_byte_s = get_byte(octree_r, wb.wb_adr_i[1:0]);
      6'h04:               rd_byte_s = get_byte(fb_r, wb.wb_adr_i[1:0]);
      6'h05, 6'h06, 6'h07: rd_byte_s = perf_byte_s;
      default:             rd_byte_s = 8'h00;
    endcase
  end

  // Bus response: single-cycle ack, read data captured on the accept edge.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      ack_r <= 1'b0;
      dat_r <= 8'h00;
    end else begin
      ack_r <= accept_s;
      if (accept_s) begin
        dat_r <= rd_s ? rd_byte_s : 8'h00;
      end
    end
  end

  // Configuration registers, writable only while the array is idle.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      mask_r    <= CORES_ALL;
      ray_buf_r <= RAY_BUF_ADR_RST;
      ray_cnt_r <= RAY_COUNT_RST;
      octree_r  <= OCTREE_ADR_RST;
      fb_r      <= FB_ADR_RST;
    end else if (cfg_ok_s) begin
      case (wb.wb_adr_i[7:2])
        6'h00:   mask_r    <= wb.wb_dat_i[N_CORES-1:0];
        6'h01:   ray_buf_r <= put_byte(ray_buf_r, wb.wb_adr_i[1:0], wb.wb_dat_i);
        6'h02:   ray_cnt_r <= put_byte(ray_cnt_r, wb.wb_adr_i[1:0], wb.wb_dat_i);
        6'h03:   octree_r  <= put_byte(octree_r, wb.wb_adr_i[1:0], wb.wb_dat_i);
        6'h04:   fb_r      <= put_byte(fb_r, wb.wb_adr_i[1:0], wb.wb_dat_i);
        default: mask_r    <= mask_r;
      endcase
    end
  end

  // Sticky status (set beats W1C on the same edge), interrupt enables and irq level.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      irq_en_r <= 3'b000;
      irq_r    <= 1'b0;
    end else begin
      done_r <= (done_r & ~w1c_s[0]) | finish_s;
      err_r  <= (err_r & ~w1c_s[2]) | err_set_s;
      if (wr_s && (wb.wb_adr_i == 8'h02)) begin
        irq_en_r <= {wb.wb_dat_i[2], 1'b0, wb.wb_dat_i[0]};
      end
      irq_r <= (done_r & irq_en_r[0]) | (err_r & irq_en_r[2]);
    end
  end

  // IDLE/RUN sequencer with per-core pending tracking and start/abort pulses.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_r   <= ST_IDLE;
      pending_r <= CORES_NONE;
      start_r   <= CORES_NONE;
      abort_r   <= 1'b0;
    end else begin
      start_r <= launch_s ? mask_r : CORES_NONE;
      abort_r <= busy_s & abort_req_s;
      case (state_r)
        ST_IDLE: begin
          if (launch_s) begin
            state_r   <= ST_RUN;
            pending_r <= mask_r;
          end
        end
        ST_RUN: begin
          if (abort_req_s || finish_s) begin
            state_r   <= ST_IDLE;
            pending_r <= CORES_NONE;
          end else begin
            pending_r <= pending_next_s;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          pending_r <= CORES_NONE;
        end
      endcase
    end
  end

  assign wb.wb_ack_o     = ack_r;
  assign wb.wb_dat_o     = dat_r;
  assign wb.wb_err_o     = 1'b0;
  assign wb.wb_rty_o     = 1'b0;
  assign rayc_start_o    = start_r;
  assign rayc_abort_o    = abort_r;
  assign ray_buf_adr_o   = ray_buf_r;
  assign ray_buf_count_o = ray_cnt_r;
  assign octree_adr_o    = octree_r;
  assign fb_adr_o        = fb_r;
  assign irq_o           = irq_r;

endmodule

// File: tb/tb_raycast_slave_mc.sv
// Self-checking bench for raycast_slave_mc: randomized register traffic and
// core-completion patterns checked against a register-map / run-state model.
module tb_raycast_slave_mc;
  localparam int          NC     = 4;
  localparam logic [31:0] RB_RST = 32'd83886084;
  localparam logic [31:0] RC_RST = 32'd307200;
  localparam logic [31:0] OC_RST = 32'd100857520;
  localparam logic [31:0] FB_RST = 32'd0;

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic [NC-1:0] rayc_start_o, rayc_finished_i;
  logic          rayc_abort_o, irq_o;
  logic [31:0]   ray_buf_adr_o, ray_buf_count_o, octree_adr_o, fb_adr_o;
  logic [31:0]   cache_hits_i, cache_miss_i;

  raycast_slave_mc_if wb();

  raycast_slave_mc #(.N_CORES(NC), .RAY_BUF_ADR_RST(RB_RST), .RAY_COUNT_RST(RC_RST),
                     .OCTREE_ADR_RST(OC_RST), .FB_ADR_RST(FB_RST)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb(wb),
    .rayc_start_o(rayc_start_o), .rayc_abort_o(rayc_abort_o),
    .ray_buf_adr_o(ray_buf_adr_o), .ray_buf_count_o(ray_buf_count_o),
    .octree_adr_o(octree_adr_o), .fb_adr_o(fb_adr_o),
    .rayc_finished_i(rayc_finished_i), .cache_hits_i(cache_hits_i),
    .cache_miss_i(cache_miss_i), .irq_o(irq_o)
  );

  always #5 wb_clk = ~wb_clk;

  int            vectors = 0;
  int            miscompares = 0;
  logic [7:0]    rd_d;
  logic [NC-1:0] st1, st2;
  logic          ab1, ab2;
  logic [31:0]   m_cfg [4];

  // Big-endian byte k (0 = most significant) of a 32-bit word.
  function automatic logic [7:0] be_byte(input logic [31:0] v, input int k);
    logic [31:0] t;
    t = v >> (8 * (3 - k));
    return t[7:0];
  endfunction

  function automatic logic [31:0] cfg_out(input int r);
    case (r)
      0:       return ray_buf_adr_o;
      1:       return ray_buf_count_o;
      2:       return octree_adr_o;
      default: return fb_adr_o;
    endcase
  endfunction

  // One classic Wishbone access; ack must arrive after one cycle and last one cycle.
  task automatic wb_access(input logic we, input logic [7:0] a, input logic [7:0] d);
    int n;
    wb.wb_adr_i = a; wb.wb_dat_i = d; wb.wb_we_i = we; wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(posedge wb_clk); #1; n++;
    end while (wb.wb_ack_o !== 1'b1 && n < 8);
    vectors++;
    if (wb.wb_ack_o !== 1'b1 || n != 1) begin
      miscompares++;
      $display("FAIL ack_latency adr=%h got ack=%b after %0d cycles, want ack=1 after 1", a, wb.wb_ack_o, n);
    end
    rd_d = wb.wb_dat_o; st1 = rayc_start_o; ab1 = rayc_abort_o;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    @(posedge wb_clk); #1;
    st2 = rayc_start_o; ab2 = rayc_abort_o;
    vectors++;
    if (wb.wb_ack_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_width adr=%h got ack=%b want 0", a, wb.wb_ack_o);
    end
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [7:0] d);
    wb_access(1'b1, a, d);
  endtask

  task automatic wb_read(input logic [7:0] a);
    wb_access(1'b0, a, 8'h00);
  endtask

  task automatic pulse_fin(input logic [NC-1:0] p);
    rayc_finished_i = p;
    @(posedge wb_clk); #1;
    rayc_finished_i = '0;
  endtask

  task automatic test_reset();
    wb_rst = 1'b1;
    repeat (3) @(posedge wb_clk);
    #1;
    vectors++;
    if ({wb.wb_ack_o, wb.wb_dat_o, rayc_start_o, rayc_abort_o, irq_o, wb.wb_err_o, wb.wb_rty_o} !== 17'd0) begin
      miscompares++;
      $display("FAIL rst_outputs got ack=%b dat=%h start=%b abort=%b irq=%b err=%b rty=%b want all 0",
               wb.wb_ack_o, wb.wb_dat_o, rayc_start_o, rayc_abort_o, irq_o, wb.wb_err_o, wb.wb_rty_o);
    end
    m_cfg[0] = RB_RST; m_cfg[1] = RC_RST; m_cfg[2] = OC_RST; m_cfg[3] = FB_RST;
    for (int r = 0; r < 4; r++) begin
      vectors++;
      if (cfg_out(r) !== m_cfg[r]) begin
        miscompares++;
        $display("FAIL rst_cfg reg%0d got %h want %h", r, cfg_out(r), m_cfg[r]);
      end
    end
    wb_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wb_read(8'(4 + k));
      vectors++;
      if (rd_d !== be_byte(RB_RST, k)) begin
        miscompares++;
        $display("FAIL rst_raybuf adr=%h got %h want %h", 8'(4 + k), rd_d, be_byte(RB_RST, k));
      end
    end
    wb_read(8'h03);
    vectors++;
    if (rd_d !== 8'h0F) begin miscompares++; $display("FAIL rst_mask got %h want 0f", rd_d); end
    wb_read(8'h01);
    vectors++;
    if (rd_d !== 8'h00) begin miscompares++; $display("FAIL rst_status got %h want 00", rd_d); end
    wb_read(8'h02);
    vectors++;
    if (rd_d !== 8'h00) begin miscompares++; $display("FAIL rst_irqen got %h want 00", rd_d); end
  endtask

  task automatic test_config();
    logic [31:0] v;
    logic [7:0]  a;
    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < 4; r++) begin
        v = $urandom;
        for (int k = 0; k < 4; k++) wb_write(8'(4 + 4 * r + k), be_byte(v, k));
        m_cfg[r] = v;
      end
      a = 8'($urandom_range(32, 255));
      wb_write(a, 8'($urandom));
      wb_read(a);
      vectors++;
      if (rd_d !== 8'h00) begin miscompares++; $display("FAIL unmapped_rd adr=%h got %h want 00", a, rd_d); end
      wb_write(8'h00, 8'h00);
      wb_read(8'h00);
      vectors++;
      if (rd_d !== 8'h00) begin miscompares++; $display("FAIL ctrl_rd got %h want 00", rd_d); end
      for (int r = 0; r < 4; r++) begin
        vectors++;
        if (cfg_out(r) !== m_cfg[r]) begin
          miscompares++;
          $display("FAIL cfg_out reg%0d got %h want %h", r, cfg_out(r), m_cfg[r]);
        end
        for (int k = 0; k < 4; k++) begin
          wb_read(8'(4 + 4 * r + k));
          vectors++;
          if (rd_d !== be_byte(m_cfg[r], k)) begin
            miscompares++;
            $display("FAIL cfg_rd adr=%h got %h want %h", 8'(4 + 4 * r + k), rd_d, be_byte(m_cfg[r], k));
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int idx, acks;
    idx = 0; acks = 0;
    wb.wb_adr_i = 8'h04; wb.wb_we_i = 1'b0; wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge wb_clk); #1;
      if (wb.wb_ack_o === 1'b1) begin
        vectors++;
        if (wb.wb_dat_o !== be_byte(m_cfg[0], idx)) begin
          miscompares++;
          $display("FAIL b2b_data idx=%0d got %h want %h", idx, wb.wb_dat_o, be_byte(m_cfg[0], idx));
        end
        acks++; idx++;
        wb.wb_adr_i = 8'(4 + idx);
      end
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    @(posedge wb_clk); #1;
    vectors++;
    if (acks != 4) begin miscompares++; $display("FAIL b2b_acks got %0d want 4 in 8 cycles", acks); end
  endtask

  task automatic test_run_basic();
    wb_write(8'h03, 8'h05);
    wb_write(8'h02, 8'h01);
    wb_write(8'h00, 8'h01);
    vectors++;
    if (st1 !== 4'b0101 || st2 !== 4'b0000) begin
      miscompares++;
      $display("FAIL start_pulse got %b then %b want 0101 then 0000", st1, st2);
    end
    pulse_fin(4'b0001);
    wb_read(8'h01);
    vectors++;
    if (rd_d !== 8'h02) begin miscompares++; $display("FAIL run_partial got %h want 02", rd_d); end
    pulse_fin(4'b0010);
    wb_read(8'h01);
    vectors++;
    if (rd_d !== 8'h02) begin miscompares++; $display("FAIL run_unmasked got %h want 02", rd_d); end
    pulse_fin(4'b0100);
    vectors++;
    if (irq_o !== 1'b0) begin miscompares++; $display("FAIL irq_delay got %b want 0", irq_o); end
    wb_read(8'h01);
    vectors++;
    if (rd_d !== 8'h01) begin miscompares++; $display("FAIL run_done got %h want 01", rd_d); end
    vectors++;
    if (irq_o !== 1'b1) begin miscompares++; $display("FAIL irq_done got %b want 1", irq_o); end
    wb_write(8'h01, 8'h01);
    vectors++;
    if (irq_o !== 1'b0) begin miscompares++; $display("FAIL irq_clear got %b want 0", irq_o); end
    wb_read(8'h01);
    vectors++;
    if (rd_d !== 8'h00) begin miscompares++; $display("FAIL done_w1c got %h want 00", rd_d); end
  endtask

  task automatic test_protect();
    wb_write(8'h03, 8'h0F);
    wb_write(8'h00, 8'h01);
    wb_write(8'h0C, 8'hAA);
    vectors++;
    if (octree_adr_o !== m_cfg[2]) begin
      miscompares++;
      $display("FAIL protect_cfg got %h want %h", octree_adr_o, m_cfg[2]);
    end
    wb_read(8'h01);
    vectors++;
    if (rd_d !== 8'h06) begin miscompares++; $display("FAIL protect_err got %h want 06", rd_d); end
    wb_write(8'h01, 8'h04);
    wb_read(8'h01);
    vectors++;
    if (rd_d !== 8'h02) begin miscompares++; $display("FAIL err_w1c got %h want 02", rd_d); end
    wb_write(8'h00, 8'h01);
    vectors++;
    if (st1 !== 4'b0000) begin miscompares++; $display("FAIL restart_pulse got %b want 0000", st1); end
    wb_read(8'h01);
    vectors++;
    if (rd_d !== 8'h06) begin miscompares++; $display("FAIL restart_err got %h want 06", rd_d); end
    wb_write(8'h01, 8'h04);
    wb_write(8'h00, 8'h03);
    vectors++;
    if (ab1 !== 1'b1 || ab2 !== 1'b0 || st1 !== 4'b0000) begin
      miscompares++;
      $display("FAIL abort_pulse got abort %b,%b start %b want 1,0 start 0000", ab1, ab2, st1);
    end
    wb_read(8'h01);
    vectors++;
    if (rd_d[1:0] !== 2'b00) begin miscompares++; $display("FAIL abort_status got %h want busy=0 done=0", rd_d); end
    wb_write(8'h00, 8'h02);
    vectors++;
    if (ab1 !== 1'b0) begin miscompares++; $display("FAIL idle_abort got %b want 0", ab1); end
  endtask

  task automatic test_mask_zero();
    wb_write(8'h03, 8'h00);
    wb_write(8'h00, 8'h01);
    vectors++;
    if (st1 !== 4'b0000) begin miscompares++; $display("FAIL zero_mask_pulse got %b want 0000", st1); end
    wb_read(8'h01);
    vectors++;
    if (rd_d !== 8'h04) begin miscompares++; $display("FAIL zero_mask_status got %h want 04", rd_d); end
    wb_write(8'h02, 8'h04);
    vectors++;
    if (irq_o !== 1'b1) begin miscompares++; $display("FAIL irq_err got %b want 1", irq_o); end
    wb_write(8'h01, 8'h04);
    vectors++;
    if (irq_o !== 1'b0) begin miscompares++; $display("FAIL irq_err_clear got %b want 0", irq_o); end
    wb_write(8'h02, 8'h00);
    wb_write(8'h03, 8'h0F);
  endtask

  task automatic test_random_runs();
    logic [NC-1:0] m, rem, p;
    int guard;
    for (int it = 0; it < 8; it++) begin
      m = NC'($urandom_range(1, 15));
      wb_write(8'h03, 8'(m));
      wb_write(8'h00, 8'h01);
      vectors++;
      if (st1 !== m || st2 !== 4'b0000) begin
        miscompares++;
        $display("FAIL rnd_start mask=%b got %b then %b", m, st1, st2);
      end
      rem = m; guard = 0;
      while (rem != 4'b0000) begin
        p = (guard < 12) ? NC'($urandom_range(0, 15)) : rem;
        pulse_fin(p);
        rem = rem & ~p;
        guard++;
        wb_read(8'h01);
        vectors++;
        if (rd_d !== ((rem != 4'b0000) ? 8'h02 : 8'h01)) begin
          miscompares++;
          $display("FAIL rnd_status mask=%b remaining=%b got %h want %h", m, rem, rd_d,
                   (rem != 4'b0000) ? 8'h02 : 8'h01);
        end
      end
      wb_write(8'h01, 8'h01);
    end
  endtask

  task automatic test_perf();
    logic [31:0] h;
`ifdef RAYC_PERF_CNT_EN
    wb_write(8'h03, 8'h01);
    wb_write(8'h00, 8'h01);
    repeat (298) @(posedge wb_clk);
    #1;
    pulse_fin(4'b0001);
    for (int k = 0; k < 4; k++) begin
      cache_hits_i = $urandom;
      wb_read(8'(8'h1C + k));
      vectors++;
      if (rd_d !== be_byte(32'd300, k)) begin
        miscompares++;
        $display("FAIL perf_cycles byte%0d got %h want %h", k, rd_d, be_byte(32'd300, k));
      end
    end
    h = $urandom;
    cache_hits_i = h;
    for (int k = 0; k < 4; k++) begin
      wb_read(8'(8'h14 + k));
      cache_hits_i = $urandom;
      vectors++;
      if (rd_d !== be_byte(h, k)) begin
        miscompares++;
        $display("FAIL perf_hits byte%0d got %h want %h", k, rd_d, be_byte(h, k));
      end
    end
    wb_write(8'h01, 8'h01);
    wb_write(8'h03, 8'h0F);
`else
    for (int k = 0; k < 12; k++) begin
      h = $urandom;
      cache_hits_i = h; cache_miss_i = ~h;
      wb_read(8'(8'h14 + k));
      vectors++;
      if (rd_d !== 8'h00) begin
        miscompares++;
        $display("FAIL perf_absent adr=%h got %h want 00", 8'(8'h14 + k), rd_d);
      end
    end
`endif
  endtask

  task automatic test_reset_midrun();
    wb_write(8'h00, 8'h01);
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;
    wb_rst = 1'b0;
    vectors++;
    if (rayc_abort_o !== 1'b0 || rayc_start_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL midrun_rst_pulses got abort=%b start=%b want 0 and 0000", rayc_abort_o, rayc_start_o);
    end
    vectors++;
    if (ray_buf_adr_o !== RB_RST) begin
      miscompares++;
      $display("FAIL midrun_rst_cfg got %h want %h", ray_buf_adr_o, RB_RST);
    end
    wb_read(8'h01);
    vectors++;
    if (rd_d !== 8'h00) begin miscompares++; $display("FAIL midrun_rst_status got %h want 00", rd_d); end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst = 1'b1;
    wb.wb_adr_i = 8'h00; wb.wb_dat_i = 8'h00; wb.wb_we_i = 1'b0;
    wb.wb_cyc_i = 1'b0;  wb.wb_stb_i = 1'b0;  wb.wb_cti_i = 3'b000; wb.wb_bte_i = 2'b00;
    rayc_finished_i = '0; cache_hits_i = 32'd0; cache_miss_i = 32'd0;
    test_reset();
    test_config();
    test_back_to_back();
    test_run_basic();
    test_protect();
    test_mask_zero();
    test_random_runs();
    test_perf();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
